// File: rtl/uart_mmio_ctrl_if.sv
// uart_mmio_ctrl_if: CPU data-memory port and UART ready/valid signals of the
// UART MMIO controller. With UART_MMIO_IRQ_EN defined the bundle also carries irq.
`timescale 1ns/1ps
interface uart_mmio_ctrl_if;
    logic [31:0] addr;
    logic        re;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        hit;
    logic        stall;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
`ifdef UART_MMIO_IRQ_EN
    logic        irq;
`endif

    // CPU core and UART core side
    modport master (
        output addr, re, we, din, stall, uart_tx_ready, uart_rx_data, uart_rx_valid,
        input  dout, hit, uart_tx_data, uart_tx_valid, uart_rx_ready
`ifdef UART_MMIO_IRQ_EN
        , input irq
`endif
    );

    // Controller side
    modport slave (
        input  addr, re, we, din, stall, uart_tx_ready, uart_rx_data, uart_rx_valid,
        output dout, hit, uart_tx_data, uart_tx_valid, uart_rx_ready
`ifdef UART_MMIO_IRQ_EN
        , output irq
`endif
    );
endinterface

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl: memory-mapped UART controller on the CPU data-memory port.
// Decodes the 0x8000_00xx window, buffers RX/TX bytes in FIFOs, runs the UART
// ready/valid handshakes and keeps a free-running cycle counter.
// Optional feature: define UART_MMIO_IRQ_EN for a maskable registered irq.
`timescale 1ns/1ps
module uart_mmio_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int PTR_W      = 3
) (
    input  logic            clk,
    input  logic            rst,
    uart_mmio_ctrl_if.slave bus
);
    localparam logic [PTR_W:0] DEPTH    = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [2:0]     W_STATUS = 3'd0;
    localparam logic [2:0]     W_RX     = 3'd1;
    localparam logic [2:0]     W_TX     = 3'd2;
    localparam logic [2:0]     W_CYCLE  = 3'd4;
    localparam logic [2:0]     W_CTRL   = 3'd6;

    logic [7:0]       rx_mem [FIFO_DEPTH];
    logic [7:0]       tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
    logic [PTR_W:0]   rx_count, tx_count, rx_count_next, tx_count_next;
    logic             tx_ovf, tx_ovf_next;
    logic [31:0]      cycle;
    logic [31:0]      dout_p1, load_data;
    logic [2:0]       word;
    logic             qual, ld, st;
    logic             rx_empty, rx_full, tx_empty, tx_full;
    logic             rx_push, rx_pop, tx_push, tx_pop, tx_req, ctrl_wr;
    logic             unused_bits;

    assign bus.hit  = bus.addr[31] && (bus.addr[30:5] == 26'd0);
    assign qual     = bus.hit && !bus.stall;
    assign word     = bus.addr[4:2];
    assign ld       = qual && bus.re;
    assign st       = qual && (bus.we != 4'd0);
    assign ctrl_wr  = st && (word == W_CTRL);

    assign rx_empty          = (rx_count == '0);
    assign rx_full           = (rx_count == DEPTH);
    assign bus.uart_rx_ready = !rx_full;
    assign rx_push           = bus.uart_rx_valid && !rx_full;
    assign rx_pop            = ld && (word == W_RX) && !rx_empty;

    assign tx_empty          = (tx_count == '0);
    assign tx_full           = (tx_count == DEPTH);
    assign bus.uart_tx_valid = !tx_empty;
    assign bus.uart_tx_data  = tx_mem[tx_rd_ptr];
    assign tx_pop            = !tx_empty && bus.uart_tx_ready;
    assign tx_req            = st && (word == W_TX);
    // A full FIFO still takes the store when the head leaves in the same cycle
    assign tx_push           = tx_req && (!tx_full || tx_pop);

    assign bus.dout    = dout_p1;
    assign unused_bits = ^{bus.addr[1:0], bus.din[31:8]};

    // Next occupancy and overflow flag; push together with pop keeps the count
    always_comb begin
        rx_count_next = rx_count;
        if (rx_push && !rx_pop)
            rx_count_next = rx_count + CNT_ONE;
        else if (!rx_push && rx_pop)
            rx_count_next = rx_count - CNT_ONE;
        tx_count_next = tx_count;
        if (tx_push && !tx_pop)
            tx_count_next = tx_count + CNT_ONE;
        else if (!tx_push && tx_pop)
            tx_count_next = tx_count - CNT_ONE;
        tx_ovf_next = tx_ovf;
        if (tx_req && !tx_push)
            tx_ovf_next = 1'b1;
        else if (ctrl_wr && bus.din[1])
            tx_ovf_next = 1'b0;
    end

    // Load mux, sampled from pre-update state of the access cycle
    always_comb begin
        load_data = 32'd0;
        case (word)
            W_STATUS: load_data = {29'd0, tx_ovf, !rx_empty, !tx_full};
            W_RX:     load_data = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd_ptr]};
            W_CYCLE:  load_data = cycle;
            default:  load_data = 32'd0;
        endcase
    end

    // Control state: pointers, counts, overflow flag, cycle counter, load data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
            rx_count  <= '0;
            tx_count  <= '0;
            tx_ovf    <= 1'b0;
            cycle     <= 32'd0;
            dout_p1   <= 32'd0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_W'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_W'(1);
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
            rx_count <= rx_count_next;
            tx_count <= tx_count_next;
            tx_ovf   <= tx_ovf_next;
            cycle    <= (ctrl_wr && bus.din[0]) ? 32'd0 : cycle + 32'd1;
            if (ld) dout_p1 <= load_data;
        end
    end

    // FIFO storage: written on push only, contents need no reset
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr] <= bus.uart_rx_data;
        if (tx_push) tx_mem[tx_wr_ptr] <= bus.din[7:0];
    end

`ifdef UART_MMIO_IRQ_EN
    logic irq_mask, irq_mask_next, irq_r;

    assign irq_mask_next = ctrl_wr ? bus.din[2] : irq_mask;
    assign bus.irq       = irq_r;

    // Interrupt registered from next-state flags so it lines up with STATUS
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_mask <= 1'b1;
            irq_r    <= 1'b0;
        end else begin
            irq_mask <= irq_mask_next;
            irq_r    <= !irq_mask_next && ((rx_count_next != '0) || tx_ovf_next);
        end
    end
`endif
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb_uart_mmio_ctrl: directed plus randomized traffic against a queue-based
// model of the register map; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_uart_mmio_ctrl;
    localparam int          DEPTH    = 8;
    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RX     = 32'h8000_0004;
    localparam logic [31:0] A_TX     = 32'h8000_0008;
    localparam logic [31:0] A_CYCLE  = 32'h8000_0010;
    localparam logic [31:0] A_CTRL   = 32'h8000_0018;

    logic clk = 1'b0;
    logic rst = 1'b0;
    uart_mmio_ctrl_if bus ();
    uart_mmio_ctrl #(.FIFO_DEPTH(DEPTH), .PTR_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    logic [31:0] exp_q[$];
    logic        m_ovf   = 1'b0;
    logic        m_mask  = 1'b1;
    logic [31:0] m_cycle = 32'd0;
    logic        taken   = 1'b0;
    logic [31:0] offs [10] = '{32'h00, 32'h04, 32'h04, 32'h08, 32'h08,
                               32'h08, 32'h10, 32'h18, 32'h0C, 32'h14};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cpu(input logic [31:0] a, input logic r, input logic [3:0] w,
                       input logic [31:0] d, input logic s);
        @(posedge clk);
        #2;
        bus.addr  = a;
        bus.re    = r;
        bus.we    = w;
        bus.din   = d;
        bus.stall = s;
    endtask

    task automatic idle();
        cpu(32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    endtask

    task automatic rd_reg(input logic [31:0] a);
        cpu(a, 1'b1, 4'd0, 32'd0, 1'b0);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        cpu(a, 1'b0, 4'hF, d, 1'b0);
    endtask

    // Reference model: register-map rules applied to queues at every clock edge
    initial forever begin : model
        logic        hit_m, q, ld_m, st_m, rx_take;
        logic [4:0]  off;
        logic [31:0] rd;
        @(posedge clk or negedge rst);
        if (!rst) begin
            rxq.delete();
            txq.delete();
            exp_q.delete();
            m_ovf   = 1'b0;
            m_mask  = 1'b1;
            m_cycle = 32'd0;
            taken   = 1'b0;
        end else begin
            hit_m = ((bus.addr & 32'hFFFF_FFE0) == 32'h8000_0000);
            q     = hit_m && !bus.stall;
            ld_m  = q && bus.re;
            st_m  = q && (bus.we != 4'd0);
            off   = {bus.addr[4:2], 2'b00};
            taken = ld_m;
            if (ld_m) begin
                case (off)
                    5'h00:   rd = {29'd0, m_ovf, rxq.size() != 0, txq.size() < DEPTH};
                    5'h04:   rd = (rxq.size() != 0) ? {24'd0, rxq[0]} : 32'd0;
                    5'h10:   rd = m_cycle;
                    default: rd = 32'd0;
                endcase
                exp_q.push_back(rd);
            end
            rx_take = bus.uart_rx_valid && (rxq.size() < DEPTH);
            if (ld_m && off == 5'h04 && rxq.size() != 0) void'(rxq.pop_front());
            if (rx_take) rxq.push_back(bus.uart_rx_data);
            if (txq.size() != 0 && bus.uart_tx_ready) void'(txq.pop_front());
            if (st_m && off == 5'h08) begin
                if (txq.size() < DEPTH) txq.push_back(bus.din[7:0]);
                else m_ovf = 1'b1;
            end
            m_cycle = m_cycle + 32'd1;
            if (st_m && off == 5'h18) begin
                if (bus.din[0]) m_cycle = 32'd0;
                if (bus.din[1]) m_ovf = 1'b0;
                m_mask = bus.din[2];
            end
        end
    end

    // Monitor: compares DUT outputs against the model mid-cycle
    initial forever begin
        @(negedge clk);
        if (taken && exp_q.size() != 0) chk("load_dout", bus.dout, exp_q.pop_front());
        chk("hit", 32'(bus.hit), 32'((bus.addr & 32'hFFFF_FFE0) == 32'h8000_0000));
        chk("tx_valid", 32'(bus.uart_tx_valid), 32'(txq.size() != 0));
        chk("rx_ready", 32'(bus.uart_rx_ready), 32'(rxq.size() < DEPTH));
        if (txq.size() != 0) chk("tx_data", 32'(bus.uart_tx_data), 32'(txq[0]));
`ifdef UART_MMIO_IRQ_EN
        chk("irq", 32'(bus.irq), 32'(!m_mask && (rxq.size() != 0 || m_ovf)));
`endif
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] v1, v2, a;
        int          tx_bias, rx_bias;
        bus.addr = 32'd0; bus.re = 1'b0; bus.we = 4'd0; bus.din = 32'd0; bus.stall = 1'b0;
        bus.uart_tx_ready = 1'b0; bus.uart_rx_data = 8'd0; bus.uart_rx_valid = 1'b0;

        // Reset then status read
        repeat (2) @(posedge clk);
        #2;
        chk("rst_dout", bus.dout, 32'd0);
        chk("rst_tx_valid", 32'(bus.uart_tx_valid), 32'd0);
        chk("rst_rx_ready", 32'(bus.uart_rx_ready), 32'd1);
        rst = 1'b1;
        rd_reg(A_STATUS);
        idle();
        chk("status_after_rst", bus.dout, 32'h1);

        // TX order
        wr_reg(A_TX, 32'h41);
        wr_reg(A_TX, 32'h42);
        wr_reg(A_TX, 32'h43);
        idle();
        bus.uart_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("tx_order", 32'(bus.uart_tx_data), 32'h41 + i);
            @(posedge clk);
            #2;
        end
        chk("tx_drained", 32'(bus.uart_tx_valid), 32'd0);
        bus.uart_tx_ready = 1'b0;

        // RX full: eight bytes fill the FIFO, the ninth waits in the UART
        bus.uart_rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx_data = 8'h10 + 8'(i);
            chk("rx_ready_fill", 32'(bus.uart_rx_ready), 32'd1);
            @(posedge clk);
            #2;
        end
        bus.uart_rx_data = 8'h18;
        chk("rx_ready_full", 32'(bus.uart_rx_ready), 32'd0);
        rd_reg(A_RX);
        rd_reg(A_RX);
        rd_reg(A_RX);
        bus.uart_rx_valid = 1'b0;
        repeat (6) rd_reg(A_RX);
        idle();
        chk("rx_ninth", bus.dout, 32'h18);

        // TX overflow and clear
        repeat (9) wr_reg(A_TX, $urandom);
        rd_reg(A_STATUS);
        idle();
        chk("status_ovf", bus.dout, 32'h4);
        wr_reg(A_CTRL, 32'h2);
        rd_reg(A_STATUS);
        idle();
        chk("status_ovf_clr", bus.dout, 32'h0);
        bus.uart_tx_ready = 1'b1;
        repeat (9) idle();
        bus.uart_tx_ready = 1'b0;

        // Cycle counter
        rd_reg(A_CYCLE);
        idle();
        v1 = bus.dout;
        repeat (3) idle();
        rd_reg(A_CYCLE);
        idle();
        v2 = bus.dout;
        chk("cycle_delta", v2 - v1, 32'd5);
        wr_reg(A_CTRL, 32'h1);
        repeat (3) idle();
        rd_reg(A_CYCLE);
        idle();
        chk("cycle_clear", bus.dout, 32'd3);

        // Stall and empty read
        bus.uart_rx_valid = 1'b1;
        bus.uart_rx_data  = 8'h5A;
        idle();
        bus.uart_rx_valid = 1'b0;
        cpu(A_RX, 1'b1, 4'd0, 32'd0, 1'b1);
        rd_reg(A_STATUS);
        idle();
        chk("status_stall", bus.dout, 32'h3);
        rd_reg(A_RX);
        idle();
        chk("rx_after_stall", bus.dout, 32'h5A);
        rd_reg(A_RX);
        idle();
        chk("rx_empty_read", bus.dout, 32'h0);
        rd_reg(A_STATUS);
        idle();
        chk("status_empty", bus.dout, 32'h1);

        // Randomized traffic with alternating back-pressure phases
        for (int i = 0; i < 3300; i++) begin
            if (i == 3000) begin
                idle();
                idle();
                #1 rst = 1'b0;
                #1;
                chk("arst_dout", bus.dout, 32'd0);
                chk("arst_tx_valid", 32'(bus.uart_tx_valid), 32'd0);
                chk("arst_rx_ready", 32'(bus.uart_rx_ready), 32'd1);
                @(posedge clk);
                #2 rst = 1'b1;
            end
            tx_bias = ((i / 200) % 2 == 0) ? 5 : 70;
            rx_bias = ((i / 300) % 2 == 0) ? 80 : 20;
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'h8000_0000 | offs[$urandom_range(0, 9)] | 32'($urandom_range(0, 3));
            cpu(a, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                $urandom, ($urandom_range(0, 4) == 0));
            bus.uart_tx_ready = ($urandom_range(0, 99) < tx_bias);
            bus.uart_rx_valid = ($urandom_range(0, 99) < rx_bias);
            bus.uart_rx_data  = 8'($urandom);
        end
        rd_reg(A_STATUS);
        idle();
        idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
- Memory-mapped I/O controller between the CPU data-memory port and the UART core.
- Decodes loads/stores to the 0x8000_00xx window; holds byte FIFOs for receive and transmit; runs the UART ready/valid handshakes on the UART side.
- Returns load data to the writeback mux with the same 1-cycle latency as dmem.
- Provides a free-running cycle counter for software timing.

Parameters:
- FIFO_DEPTH, 8, entries per RX and TX FIFO; power of two, minimum 2.
- PTR_W, 3, log2(FIFO_DEPTH).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  32  CPU data address, valid in the access cycle.
- re  in  1  CPU load strobe.
- we  in  4  CPU store byte mask; any bit set means a store.
- din  in  32  CPU store data.
- dout  out  32  load data; valid in the cycle after re.
- hit  out  1  combinational; addr[31]==1 and addr[30:5]==0.
- uart_tx_data  out  8  byte to the UART transmitter.
- uart_tx_valid  out  1  TX FIFO not empty.
- uart_tx_ready  in  1  UART transmitter can accept a byte.
- uart_rx_data  in  8  byte from the UART receiver.
- uart_rx_valid  in  1  receiver holds a byte.
- uart_rx_ready  out  1  RX FIFO not full.
- stall  in  1  CPU stall; when high, re and we are ignored.

Behaviour:
- Register map (word addresses; addr[1:0] ignored):
  - 0x8000_0000 STATUS (read-only): {29'b0, tx_ovf, rx_nonempty, tx_nonfull}.
  - 0x8000_0004 RX_DATA (read): {24'b0, rx head byte}; the read pops the RX FIFO.
  - 0x8000_0008 TX_DATA (write): any we bit set pushes din[7:0].
  - 0x8000_0010 CYCLE (read): 32-bit cycle count.
  - 0x8000_0018 CTRL (write): din[0]=1 clears CYCLE to 0; din[1]=1 clears tx_ovf.
- Other hits: loads return 0; stores have no effect.
- Access qualification: an access acts only when hit=1 and stall=0.
- Load latency:
  - dout is registered and updates in the cycle after a qualified re.
  - dout holds its value in all other cycles.
  - The RX pop takes effect in the re cycle.
- RX FIFO:
  - Push when uart_rx_valid and uart_rx_ready, where uart_rx_ready = count < FIFO_DEPTH.
  - When full, uart_rx_ready=0 and the byte stays in the UART; no data is lost.
  - Reading RX_DATA while empty returns 0 and does not pop.
- TX FIFO:
  - Head byte is driven combinationally on uart_tx_data; uart_tx_valid = count != 0.
  - Pop when uart_tx_valid and uart_tx_ready.
  - A store while full is dropped and sets sticky tx_ovf.
- Simultaneous push and pop on either FIFO:
  - Count unchanged; both pointers advance.
  - If count==0, push only.
  - If full, the TX store is accepted when a pop occurs in the same cycle.
- Pointers are PTR_W bits and wrap modulo FIFO_DEPTH. Count is PTR_W+1 bits.
- CYCLE:
  - Increments by 1 every clock and wraps 0xFFFF_FFFF -> 0.
  - A CTRL clear sets it to 0 in the next cycle; the increment is suppressed that cycle.
- Reset (rst=0, asynchronous), from any state including mid-handshake:
  - Both FIFOs empty; tx_ovf=0, CYCLE=0, dout=0.
  - uart_tx_valid=0, uart_rx_ready=1.
  - FIFO contents are don't-care.
  - Deassertion is synchronised by the top level.

Optional Feature:
- Macro UART_MMIO_IRQ_EN.
- When defined:
  - Adds output irq (1 bit, registered), high when rx_nonempty or tx_ovf.
  - Adds CTRL bit din[2] = irq_mask; irq is forced to 0 while the mask is 1.
  - Mask resets to 1.
- When undefined:
  - No irq port.
  - CTRL bit 2 is ignored.

Test Plan:
- Reset then status read:
  - rst=0 for 2 cycles, then a load to 0x8000_0000.
  - dout=0x0000_0001 one cycle later; uart_tx_valid=0; uart_rx_ready=1.
- TX order:
  - Store 0x41, 0x42, 0x43 to 0x8000_0008 with uart_tx_ready=0.
  - Raise ready for 3 cycles: uart_tx_data sequence is 0x41, 0x42, 0x43, then uart_tx_valid=0.
- RX full:
  - Drive 9 bytes 0x10..0x18 with uart_rx_valid held.
  - uart_rx_ready falls after the 8th byte.
  - 8 loads from 0x8000_0004 return 0x10..0x17.
  - After the first pop, 0x18 is accepted and the 9th load returns 0x18.
- TX overflow:
  - Make 9 stores with uart_tx_ready=0; status reads 0x0000_0004.
  - CTRL store with din=0x2 clears the overflow bit; then the status read returns 0x0000_0000.
- Cycle counter:
  - Read 0x8000_0010 twice, 5 cycles apart: difference is 5.
  - CTRL store din=0x1: the next read returns the number of cycles elapsed since the clear.
- Stall and empty read:
  - Load RX_DATA with stall=1 and 1 byte queued: no pop; status still 0x3.
  - Load with the RX FIFO empty returns 0x0000_0000 and the pointers do not move.
